// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-serial boot loader: the core is held in reset until a length-prefixed
// big-endian image has been streamed in, after which the ROM serves combinational fetches.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  output logic                  ld_ready_o,
  input  logic                  reload_i,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DEPTH_LOG2:0]   loaded_words_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [16:0] DEPTH_N = 17'(DEPTH);

  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;

  state_t                state, state_nx;
  logic [15:0]           len;
  logic [23:0]           asm_word;
  logic [1:0]            byte_cnt;
  logic [DEPTH_LOG2:0]   word_cnt;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  word_done;
  logic                  clear;
  logic [16:0]           len_n;
  logic [16:0]           word_cnt_inc;

  assign ld_ready_o   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
  assign accept       = ld_valid_i & ld_ready_o;
  assign len_n        = {1'b0, len[15:8], ld_byte_i};
  assign word_cnt_inc = 17'(word_cnt) + 17'd1;
  assign word_done    = accept && (state == S_DATA) && (byte_cnt == 2'd3);
  assign clear        = ((state == S_DONE) || (state == S_ERR)) && reload_i;

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_n == 17'd0)       state_nx = S_DONE;
          else if (len_n > DEPTH_N) state_nx = S_ERR;
          else                      state_nx = S_DATA;
        end
      end
      S_DATA:   if (word_done && (word_cnt_inc == {1'b0, len})) state_nx = S_DONE;
      S_DONE:   if (reload_i) state_nx = S_LEN_HI;
      S_ERR:    if (reload_i) state_nx = S_LEN_HI;
      default:  state_nx = S_LEN_HI;
    endcase
  end

  // Status flags are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_LEN_HI;
      len            <= '0;
      asm_word       <= '0;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      loaded_words_o <= '0;
      cpu_rst_o      <= 1'b1;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_rst_o <= (state_nx != S_DONE);
      done_o    <= (state_nx == S_DONE);
      err_o     <= (state_nx == S_ERR);
      if (clear) begin
        len            <= '0;
        asm_word       <= '0;
        byte_cnt       <= '0;
        word_cnt       <= '0;
        loaded_words_o <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_HI: len[15:8] <= ld_byte_i;
          S_LEN_LO: len[7:0]  <= ld_byte_i;
          S_DATA: begin
            asm_word <= {asm_word[15:0], ld_byte_i};
            byte_cnt <= byte_cnt + 2'd1;
            if (word_done) begin
              word_cnt       <= word_cnt + 1'b1;
              loaded_words_o <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Array contents deliberately survive reset; loaded_words_o gates what is readable.
  always_ff @(posedge clk) begin
    if (word_done) mem[word_cnt[DEPTH_LOG2-1:0]] <= {asm_word, ld_byte_i};
  end

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_hi_zero;
  logic                  rd_ok;
  logic                  unused_addr_bits;

  assign rd_idx           = rom_addr_i[DEPTH_LOG2+1:2];
  assign rd_hi_zero       = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
  assign rd_ok            = rom_ce_i && done_o && rd_hi_zero && ({1'b0, rd_idx} < loaded_words_o);
  assign rom_data_o       = rd_ok ? mem[rd_idx] : 32'h0;
  assign unused_addr_bits = ^rom_addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: stimulus queues expected values, a negedge monitor compares them.
module tb_inst_rom_loader;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        reload;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [DL:0] loaded_words;

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_ready_o(ld_ready),
    .reload_i(reload), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
    .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err), .loaded_words_o(loaded_words)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_loaded;
  bit          ref_done;
  bit          ref_err;
  bit          rnd_side;

  function automatic logic [31:0] actual_of(int kind);
    case (kind)
      0:       return rom_data;
      1:       return {31'd0, cpu_rst};
      2:       return {31'd0, done};
      3:       return {31'd0, err};
      4:       return {31'd0, ld_ready};
      default: return 32'(loaded_words);
    endcase
  endfunction

  always @(negedge clk) begin
    if (probe) begin
      while (sb.size() > 0) begin
        chk_t        c;
        logic [31:0] act;
        c = sb.pop_front();
        act = actual_of(c.kind);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: actual=%h expected=%h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    sb.push_back(c);
  endtask

  task automatic sample();
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic ce);
    int idx;
    if (!ce || !ref_done || (addr >> (DL + 2)) != 0) return 32'h0;
    idx = int'(addr >> 2);
    if (idx >= ref_loaded) return 32'h0;
    return ref_mem[idx];
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
  endfunction

  task automatic expect_status(input string tag);
    expect_val({tag, "_cpu_rst"}, 1, {31'd0, !ref_done});
    expect_val({tag, "_done"},    2, {31'd0, ref_done});
    expect_val({tag, "_err"},     3, {31'd0, ref_err});
    expect_val({tag, "_ready"},   4, {31'd0, !ref_done && !ref_err});
    expect_val({tag, "_loaded"},  5, 32'(ref_loaded));
  endtask

  task automatic model_clear();
    ref_done = 1'b0; ref_err = 1'b0; ref_loaded = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    if (rnd_side) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ld_valid = 1'b1;
    ld_byte  = b;
    if (rnd_side) begin
      reload   = 1'($urandom_range(0, 1));
      rom_ce   = 1'($urandom_range(0, 1));
      rom_addr = rand_addr();
    end
    expect_val("load_ready",   4, 32'd1);
    expect_val("load_cpu_rst", 1, 32'd1);
    expect_val("load_done",    2, 32'd0);
    expect_val("load_read",    0, ref_read(rom_addr, rom_ce));
    sample();
    @(posedge clk); #1;
    ld_valid = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic load_image(input logic [7:0] img[$], input string tag);
    int n;
    foreach (img[i]) send_byte(img[i]);
    n = {img[0], img[1]};
    if (n == 0) begin
      ref_done = 1'b1; ref_loaded = 0;
    end else if (n > DEPTH) begin
      ref_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++)
        ref_mem[w] = {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]};
      ref_loaded = n;
      ref_done   = 1'b1;
    end
    expect_status(tag);
    sample();
  endtask

  task automatic make_img(input logic [31:0] words[$], output logic [7:0] img[$]);
    img = {};
    img.push_back(8'(words.size() >> 8));
    img.push_back(8'(words.size()));
    foreach (words[i]) begin
      img.push_back(words[i][31:24]); img.push_back(words[i][23:16]);
      img.push_back(words[i][15:8]);  img.push_back(words[i][7:0]);
    end
  endtask

  task automatic do_reload(input string tag);
    @(posedge clk); #1 reload = 1'b1;
    @(posedge clk); #1 reload = 1'b0;
    model_clear();
    expect_status(tag);
    sample();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    expect_status(tag);
    sample();
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic ce,
                          input logic [31:0] exp);
    rom_addr = addr;
    rom_ce   = ce;
    expect_val(name, 0, exp);
    sample();
  endtask

  task automatic rand_reads(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] a;
      logic        ce;
      a  = rand_addr();
      ce = 1'($urandom_range(0, 1));
      read_chk("rand_read", a, ce, ref_read(a, ce));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  img[$];
    logic [7:0]  case1[$];
    logic [31:0] words[$];

    rst = 1'b1; ld_valid = 1'b0; ld_byte = 8'h0; reload = 1'b0;
    rom_ce = 1'b0; rom_addr = 32'h0; rnd_side = 1'b0;
    model_clear();
    #12 rst = 1'b0;
    expect_status("por");
    sample();

    // directed image from the bring-up program
    case1 = '{8'h00, 8'h03, 8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02,
              8'h00, 8'h22, 8'h18, 8'h20};
    load_image(case1, "t1");
    expect_val("t1_loaded3", 5, 32'd3);
    expect_val("t1_released", 1, 32'd0);
    sample();
    read_chk("t1_a0",  32'h0,    1'b1, 32'h34010001);
    read_chk("t1_a4",  32'h4,    1'b1, 32'h34020002);
    read_chk("t1_a8",  32'h8,    1'b1, 32'h00221820);
    read_chk("t1_aC",  32'hC,    1'b1, 32'h0);
    read_chk("t1_a6",  32'h6,    1'b1, 32'h34020002);
    read_chk("t1_ce0", 32'h4,    1'b0, 32'h0);
    read_chk("t1_hi",  32'h1000, 1'b1, 32'h0);

    // empty image
    do_reload("t2_reload");
    img = '{8'h00, 8'h00};
    load_image(img, "t2");
    read_chk("t2_a0", 32'h0, 1'b1, 32'h0);
    read_chk("t2_a4", 32'h4, 1'b1, 32'h0);

    // oversize image: 1025 words
    do_reload("t3_reload");
    img = '{8'h04, 8'h01};
    load_image(img, "t3");
    expect_val("t3_err",   3, 32'd1);
    expect_val("t3_ready", 4, 32'd0);
    sample();
    read_chk("t3_a0", 32'h0, 1'b1, 32'h0);
    do_reload("t3_clear");

    // same image with valid gaps, random fetch/reload noise
    rnd_side = 1'b1;
    load_image(case1, "t4");
    read_chk("t4_a0", 32'h0, 1'b1, 32'h34010001);
    read_chk("t4_a8", 32'h8, 1'b1, 32'h00221820);
    rand_reads(20);
    rnd_side = 1'b0;

    // reset in the middle of the second word
    do_reload("t5_reload");
    for (int i = 0; i < 7; i++) send_byte(case1[i]);
    do_reset("t5_reset");
    expect_val("t5_loaded0", 5, 32'd0);
    sample();
    read_chk("t5_a0_dead", 32'h0, 1'b1, 32'h0);
    load_image(case1, "t5");
    read_chk("t5_a8", 32'h8, 1'b1, 32'h00221820);
    read_chk("t5_aC", 32'hC, 1'b1, 32'h0);

    // shorter reload hides stale words
    do_reload("t6_reload");
    img = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_image(img, "t6");
    read_chk("t6_a0", 32'h0, 1'b1, 32'hFFFFFFFF);
    read_chk("t6_a4", 32'h4, 1'b1, 32'h0);

    // random images
    for (int k = 0; k < 5; k++) begin
      do_reload("t7_reload");
      words = {};
      repeat ($urandom_range(1, 12)) words.push_back($urandom);
      make_img(words, img);
      rnd_side = 1'b1;
      load_image(img, "t7");
      rnd_side = 1'b0;
      rand_reads(10);
    end

    // full-depth image
    do_reload("t8_reload");
    words = {};
    repeat (DEPTH) words.push_back($urandom);
    make_img(words, img);
    load_image(img, "t8");
    expect_val("t8_loaded", 5, 32'(DEPTH));
    sample();
    read_chk("t8_last",  32'(4 * (DEPTH - 1)), 1'b1, words[DEPTH-1]);
    read_chk("t8_first", 32'h0, 1'b1, words[0]);
    read_chk("t8_past",  32'(4 * DEPTH), 1'b1, 32'h0);
    rand_reads(10);

    @(posedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
